// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART TX arbiter.
package uart_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEFAULT          = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 65536;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first set request bit scanning upward from ptr+1.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    winner_o,
    output logic             any_o
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[idx]) begin
                winner_o = IW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter for the UART TX FIFO write port.
// Optional stall timeout on a locked grant: define UART_ARB_TIMEOUT_EN.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next requester round-robin, accept nothing
// ARB_GRANT | grant_id owns the port until its last byte (or timeout)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ          = N_REQ_DEFAULT,
    parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int IW             = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic                 tx_ready_i,
    output logic                 uart_fifo_write_en_o,
    output logic [7:0]           uart_fifo_data_o,
    output logic [IW-1:0]        grant_id_o,
    output logic                 busy_o,
    output logic                 timeout_pulse_o
);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           wr_en_q, wr_en_d;
    logic [7:0]     data_q, data_d;
    logic [IW-1:0]  winner;
    logic           any_req;
    logic           accept;
    logic           timeout;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // The write-enable term masks the FIFO full flag's one-cycle lag.
    assign accept = (state_q == ARB_GRANT) && req_valid_i[grant_q] && tx_ready_i && !wr_en_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == ARB_GRANT) && tx_ready_i && !accept
                     && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Stall counter: advances only on idle cycles with the FIFO able to take data.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ARB_GRANT || accept || timeout) begin
            cnt_d = '0;
        end else if (tx_ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, grant bookkeeping and accept pulse.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = accept;
        data_d      = data_q;
        req_ready_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    req_ready_o[grant_q] = 1'b1;
                    data_d = req_data_i[{grant_q, 3'b000} +: 8];
                    if (req_last_i[grant_q]) begin
                        rr_ptr_d = grant_q;
                        state_d  = ARB_IDLE;
                    end
                end else if (timeout) begin
                    rr_ptr_d = grant_q;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; rr_ptr resets so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IW'(N_REQ - 1);
            wr_en_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            data_q   <= data_d;
        end
    end

    assign uart_fifo_write_en_o = wr_en_q;
    assign uart_fifo_data_o     = data_q;
    assign grant_id_o           = grant_q;
    assign busy_o               = (state_q == ARB_GRANT);
    assign timeout_pulse_o      = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Timeout scenario runs when
// UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_ready;
    logic           wr_en;
    logic [7:0]     wr_data;
    logic [1:0]     grant_id;
    logic           busy, tpulse;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_valid_i          (req_valid),
        .req_data_i           (req_data),
        .req_last_i           (req_last),
        .req_ready_o          (req_ready),
        .tx_ready_i           (tx_ready),
        .uart_fifo_write_en_o (wr_en),
        .uart_fifo_data_o     (wr_data),
        .grant_id_o           (grant_id),
        .busy_o               (busy),
        .timeout_pulse_o      (tpulse)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Requester-side message queues: {last, byte}; presented = currently offered.
    logic [8:0]  msg_q [N][$];
    logic [N-1:0] presented;
    // Reference model: owner of the port (-1 none), rotation pointer, write lag, stall count.
    int owner, ptr, lag, tcnt;
    int tx_pct, gap_pct;
    logic force_low;

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int wr_times[$];
    int mon_ids[$];
    int pulse_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every FIFO write must match the oldest predicted byte and owner.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tpulse === 1'b1) pulse_times.push_back(cyc);
            if (wr_en === 1'b1) begin
                wr_times.push_back(cyc);
                mon_ids.push_back(int'(grant_id));
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
                    chk("wr_owner", 32'(grant_id), 32'(mon_e[15:8]));
                end
            end
        end
    end

    function automatic logic pending();
        logic p;
        p = (presented != '0);
        for (int i = 0; i < N; i++) if (msg_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic add_msg(input int id, input int len);
        for (int k = 0; k < len; k++)
            msg_q[id].push_back({(k == len - 1), 8'($urandom)});
    endtask

    task automatic model_reset();
        owner = -1; ptr = N - 1; lag = 0; tcnt = 0;
        presented = '0;
        for (int i = 0; i < N; i++) msg_q[i].delete();
        exp_q.delete();
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model after posedge.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic acc, fire, found;
        logic [8:0] head;
        int idx;
        for (int i = 0; i < N; i++) begin
            if (!presented[i] && msg_q[i].size() > 0 && $urandom_range(99) >= gap_pct)
                presented[i] = 1'b1;
            req_valid[i] = presented[i];
            if (presented[i]) begin
                head = msg_q[i][0];
                req_data[8*i +: 8] = head[7:0];
                req_last[i] = head[8];
            end else begin
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom_range(1));
            end
        end
        tx_ready = force_low ? 1'b0 : ($urandom_range(99) < tx_pct);
        acc = (owner >= 0) && presented[owner] && tx_ready && (lag == 0);
        exp_ready = '0;
        if (acc) exp_ready[owner] = 1'b1;
        fire = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        if (owner >= 0 && !acc && tx_ready && tcnt == T - 1) fire = 1'b1;
`endif
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(owner >= 0));
        if (owner >= 0) chk("grant_id", 32'(grant_id), owner);
        chk("timeout_pulse", 32'(tpulse), 32'(fire));
        @(posedge clk);
        #1;
        if (owner < 0) begin
            lag = 0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (ptr + k) % N;
                if (presented[idx] && !found) begin
                    owner = idx; tcnt = 0; found = 1'b1;
                end
            end
        end else if (acc) begin
            head = msg_q[owner].pop_front();
            exp_q.push_back({8'(owner), head[7:0]});
            presented[owner] = 1'b0;
            lag = 1; tcnt = 0;
            if (head[8]) begin
                ptr = owner; owner = -1;
            end
        end else begin
            lag = 0;
            if (fire) begin
                ptr = owner; owner = -1;
            end else if (tx_ready) begin
                tcnt++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((pending() || owner >= 0) && c < budget) begin
            step();
            c++;
        end
        chk("drained_within_budget", 32'(c < budget), 32'd1);
        repeat (2) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Expected owner sequence packed as hex nibbles, oldest first.
    task automatic chk_seq(input string name, input int n, input logic [31:0] seq);
        chk({name, "_len"}, 32'(mon_ids.size()), 32'(n));
        for (int k = 0; k < n && k < mon_ids.size(); k++)
            chk(name, 32'(mon_ids[k]), 32'(seq[4*(n-1-k) +: 4]));
    endtask

    initial begin
        int nb;
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
        force_low = 1'b0; tx_pct = 100; gap_pct = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_tpulse", 32'(tpulse), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester, three bytes, two cycles apart.
        wr_times.delete(); mon_ids.delete();
        msg_q[0].push_back(9'h041); msg_q[0].push_back(9'h042); msg_q[0].push_back(9'h143);
        drain(100);
        chk("t1_writes", 32'(wr_times.size()), 3);
        if (wr_times.size() == 3) begin
            chk("t1_gap01", 32'(wr_times[1] - wr_times[0]), 2);
            chk("t1_gap12", 32'(wr_times[2] - wr_times[1]), 2);
        end
        chk("t1_idle", 32'(busy), 0);

        // Requesters 1 and 2 contend; 1 has a second message queued.
        mon_ids.delete();
        add_msg(1, 2); add_msg(2, 2); add_msg(1, 2);
        drain(200);
        chk_seq("t2_order", 6, 32'h112211);

        // Requester 0 holds the lock for 4 bytes while 3 waits.
        mon_ids.delete();
        add_msg(0, 4);
        repeat (2) step();
        add_msg(3, 2);
        drain(200);
        chk_seq("t3_order", 6, 32'h000033);

        // tx_ready low for 100 cycles mid-message.
        mon_ids.delete();
        add_msg(1, 4);
        repeat (3) step();
        nb = wr_times.size();
        force_low = 1'b1;
        repeat (100) step();
        chk("t4_no_write_stalled", 32'(wr_times.size() - nb), 0);
        force_low = 1'b0;
        drain(200);
        chk_seq("t4_order", 4, 32'h1111);

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 2 abandons its message; the lock must time out.
        mon_ids.delete(); wr_times.delete(); pulse_times.delete();
        msg_q[2].push_back(9'h05A);
        repeat (2) step();
        add_msg(3, 2);
        drain(300);
        chk_seq("t5_order", 3, 32'h233);
        chk("t5_pulses", 32'(pulse_times.size()), 1);
        if (pulse_times.size() == 1 && wr_times.size() > 0)
            chk("t5_pulse_delay", 32'(pulse_times[0] - wr_times[0]), T - 1);
`endif

        // Randomized traffic.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                nb = $urandom_range(2);
                for (int m = 0; m < nb; m++) add_msg(i, $urandom_range(1, 4));
            end
            tx_pct = $urandom_range(40, 100);
            gap_pct = $urandom_range(0, 40);
            drain(3000);
        end
        tx_pct = 100; gap_pct = 0;

        // Reset during a grant with a write pending.
        add_msg(2, 3);
        nb = 0;
        while (exp_q.size() == 0 && nb < 20) begin step(); nb++; end
        chk("t7_write_pending", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_wr_en", 32'(wr_en), 0);
        chk("t7_data", 32'(wr_data), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_grant", 32'(grant_id), 0);
        chk("t7_ready", 32'(req_ready), 0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_ids.delete();
        for (int i = 0; i < N; i++) add_msg(i, 1);
        step();
        chk("t7_first_grant", 32'(grant_id), 0);
        chk("t7_first_busy", 32'(busy), 1);
        drain(200);
        chk_seq("t7_order", 4, 32'h0123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
